sweep_sample_ctrl: RTL and testbench

- Frequency-sweep sample scheduler for the impedance front end.
- Steps through a writable table of divider terminal counts, one entry per excitation point.
- For each point it runs a programmable divider, waits a settle interval, and emits exactly SAMPLES_PER_PT sample strobes.
- Hands each completed point to the downstream processing logic with a done/ack handshake. Sits between the host/config logic and the ADC capture path.

---
 rtl/sweep_sample_ctrl.sv | 160 ++++++++++++++++
 tb/tb_sweep_sample_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sweep_sample_ctrl.sv
// sweep_sample_ctrl: frequency-sweep sample scheduler for the impedance front end.
// Walks a writable table of divider terminal counts, one entry per sweep point.
// For each point it runs the sample-clock divider, waits a settle interval,
// emits SAMPLES_PER_PT strobes, then hands the point off with pt_done/pt_ack.
// Optional build macro CONT_SWEEP_EN: after the last point is acked, wrap to
// point 0 and keep sweeping until abort or rst (FIN/done never occur).
module sweep_sample_ctrl #(
    parameter int NUM_PTS        = 6,
    parameter int SAMPLES_PER_PT = 512,
    parameter int SETTLE_CYC     = 100000,
    parameter int DIV_W          = 20
) (
    input  logic             clk_100m,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic             tbl_we,
    input  logic [2:0]       tbl_addr,
    input  logic [DIV_W-1:0] tbl_data,
    output logic             samp_clk,
    output logic             sample_stb,
    output logic [2:0]       pt_idx,
    output logic             pt_start,
    output logic             pt_done,
    input  logic             pt_ack,
    output logic             busy,
    output logic             done
);

    localparam int IDX_W = (NUM_PTS > 1) ? $clog2(NUM_PTS) : 1;
    localparam int SMP_W = $clog2(SAMPLES_PER_PT + 1);
    localparam int SET_W = $clog2(SETTLE_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_SAMPLE,
        S_WAIT_ACK,
        S_FIN
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [DIV_W-1:0]   tbl [NUM_PTS];
    logic [DIV_W-1:0]   tbl_rd;
    logic [DIV_W-1:0]   tc;
    logic [DIV_W-1:0]   div_cnt;
    logic               samp_clk_d;
    logic [SET_W-1:0]   settle_cnt;
    logic [SMP_W-1:0]   samp_cnt;
    logic               last_pt;
    logic               div_run;

    assign tbl_rd  = tbl[pt_idx[IDX_W-1:0]];
    assign last_pt = (pt_idx == 3'(NUM_PTS - 1));

    // Divider only advances while staying inside SETTLE/SAMPLE; any exit
    // (end of point, abort) clears it so samp_clk is parked low.
    assign div_run = ((state == S_SETTLE) || (state == S_SAMPLE)) &&
                     ((state_nxt == S_SETTLE) || (state_nxt == S_SAMPLE));

    // Next-state decode and Moore handshake outputs; abort overrides everything.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        pt_start  = 1'b0;
        pt_done   = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                pt_start = (settle_cnt == '0);
                if (settle_cnt == SET_W'(SETTLE_CYC - 1)) state_nxt = S_SAMPLE;
            end
            S_SAMPLE: begin
                if (sample_stb && (samp_cnt == SMP_W'(SAMPLES_PER_PT - 1)))
                    state_nxt = S_WAIT_ACK;
            end
            S_WAIT_ACK: begin
                pt_done = 1'b1;
                if (pt_ack) begin
`ifdef CONT_SWEEP_EN
                    state_nxt = S_LOAD;
`else
                    state_nxt = last_pt ? S_FIN : S_LOAD;
`endif
                end
            end
            S_FIN: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
        busy = (state != S_IDLE);
        if (abort) state_nxt = S_IDLE;
    end

    // State register, table, point index, divider, counters and strobe.
    always_ff @(posedge clk_100m) begin
        if (rst) begin
            state      <= S_IDLE;
            pt_idx     <= '0;
            tc         <= '0;
            div_cnt    <= '0;
            samp_clk   <= 1'b0;
            samp_clk_d <= 1'b0;
            sample_stb <= 1'b0;
            settle_cnt <= '0;
            samp_cnt   <= '0;
            for (int unsigned i = 0; i < NUM_PTS; i++) tbl[i] <= '0;
        end else begin
            state      <= state_nxt;
            samp_clk_d <= samp_clk;

            if (tbl_we && (state == S_IDLE) && (32'(tbl_addr) < NUM_PTS))
                tbl[tbl_addr[IDX_W-1:0]] <= tbl_data;

            // Last-point wrap to 0 is only reachable in continuous builds.
            if ((state == S_IDLE) && (state_nxt == S_LOAD))
                pt_idx <= '0;
            else if ((state == S_WAIT_ACK) && (state_nxt == S_LOAD))
                pt_idx <= last_pt ? '0 : pt_idx + 3'd1;

            if (state == S_LOAD) begin
                tc         <= (tbl_rd == '0) ? DIV_W'(1) : tbl_rd;
                settle_cnt <= '0;
                samp_cnt   <= '0;
            end

            if ((state == S_SETTLE) && (state_nxt == S_SETTLE))
                settle_cnt <= settle_cnt + SET_W'(1);

            if ((state == S_SAMPLE) && sample_stb)
                samp_cnt <= samp_cnt + SMP_W'(1);

            if (div_run) begin
                if (div_cnt == tc) begin
                    div_cnt  <= '0;
                    samp_clk <= ~samp_clk;
                end else begin
                    div_cnt  <= div_cnt + DIV_W'(1);
                end
            end else begin
                div_cnt  <= '0;
                samp_clk <= 1'b0;
            end

            // Strobe lands one cycle after samp_clk is first seen high.
            sample_stb <= (state == S_SAMPLE) && samp_clk && !samp_clk_d && !abort;
        end
    end

endmodule

// File: tb/tb_sweep_sample_ctrl.sv
// Bench for sweep_sample_ctrl (NUM_PTS=2, SAMPLES_PER_PT=4, SETTLE_CYC=10).
// Control vectors come from a table; sweep timing is checked by a scoreboard
// of expected pt_start / sample_stb / done events, timed analytically from
// the terminal counts. Build with CONT_SWEEP_EN for the continuous-sweep run.
module tb_sweep_sample_ctrl;

    localparam int NP     = 2;
    localparam int SPP    = 4;
    localparam int SETTLE = 10;
    localparam int DW     = 20;

    logic          clk_100m = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          tbl_we = 1'b0;
    logic [2:0]    tbl_addr = '0;
    logic [DW-1:0] tbl_data = '0;
    logic          pt_ack = 1'b1;
    logic          samp_clk, sample_stb, pt_start, pt_done, busy, done;
    logic [2:0]    pt_idx;

    sweep_sample_ctrl #(
        .NUM_PTS(NP), .SAMPLES_PER_PT(SPP), .SETTLE_CYC(SETTLE), .DIV_W(DW)
    ) dut (
        .clk_100m(clk_100m), .rst(rst), .start(start), .abort(abort),
        .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_data(tbl_data),
        .samp_clk(samp_clk), .sample_stb(sample_stb), .pt_idx(pt_idx),
        .pt_start(pt_start), .pt_done(pt_done), .pt_ack(pt_ack),
        .busy(busy), .done(done)
    );

    always #5 clk_100m = ~clk_100m;

    int cyc = 0;
    always @(posedge clk_100m) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;

    typedef enum logic [1:0] { EV_PTSTART, EV_STB, EV_DONE } ev_kind_t;
    typedef struct { ev_kind_t kind; int c; int idx; } ev_t;
    ev_t sb[$];
    bit  mon_en = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h, want 0x%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic push_ev(input ev_kind_t k, input int c, input int idx);
        ev_t e;
        e.kind = k; e.c = c; e.idx = idx;
        sb.push_back(e);
    endtask

    // Expected events for one point whose LOAD cycle is l. samp_clk rises at
    // l+1+(2k+1)(tc+1); only rises inside SAMPLE (from l+1+SETTLE) strobe,
    // one cycle later. w = first WAIT_ACK cycle.
    task automatic push_point(input int l, input int tc, input int idx, output int w);
        int n, r;
        n = 0;
        w = 0;
        push_ev(EV_PTSTART, l + 1, idx);
        for (int k = 0; n < SPP; k++) begin
            r = l + 1 + (2 * k + 1) * (tc + 1);
            if (r >= l + 1 + SETTLE) begin
                push_ev(EV_STB, r + 1, idx);
                n++;
                w = r + 2;
            end
        end
    endtask

    task automatic sb_check(input ev_kind_t k);
        ev_t e;
        n_vec++;
        if (sb.size() == 0) begin
            n_err++;
            $display("FAIL sb_unexpected: got %s at cyc %0d idx %0d, want no event",
                     k.name(), cyc, pt_idx);
        end else begin
            e = sb.pop_front();
            if (e.kind != k || e.c != cyc || e.idx != int'(pt_idx)) begin
                n_err++;
                $display("FAIL sb_event: got %s cyc %0d idx %0d, want %s cyc %0d idx %0d",
                         k.name(), cyc, pt_idx, e.kind.name(), e.c, e.idx);
            end
        end
    endtask

    always @(negedge clk_100m) begin
        if (mon_en) begin
            if (pt_start)   sb_check(EV_PTSTART);
            if (sample_stb) sb_check(EV_STB);
            if (done)       sb_check(EV_DONE);
        end
    end

    task automatic wr(input logic [2:0] a, input logic [DW-1:0] d);
        tbl_we = 1'b1; tbl_addr = a; tbl_data = d;
        @(negedge clk_100m);
        tbl_we = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk_100m);
    endtask

    // Full two-point sweep with pt_ack tied high; optionally attempts a
    // table write (addr 1, data 7) while busy.
    task automatic run_sweep(input int tc0, input int tc1, input bit wr_busy);
        int l, w0, w1;
        start = 1'b1;
        l = cyc + 1;
        @(negedge clk_100m);
        start = 1'b0;
        check("load_busy_idx", {busy, pt_idx}, 4'b1000);
        push_point(l, tc0, 0, w0);
        push_point(w0 + 1, tc1, 1, w1);
        push_ev(EV_DONE, w1 + 1, 1);
        tbl_addr = 3'd1; tbl_data = 7;
        while (cyc < w1 + 3) begin
            tbl_we = wr_busy && (cyc == l + 5);
            @(negedge clk_100m);
        end
        tbl_we = 1'b0;
        check("sweep_end_busy", busy, 0);
        check("sweep_sb_empty", sb.size(), 0);
    endtask

    typedef struct {
        bit         rst, start, abort;
        logic [8:0] exp;   // {busy, pt_start, pt_done, done, samp_clk, sample_stb, pt_idx}
    } vec_t;
    vec_t vecs[12];

    initial begin
        int l, w0, w1, a;
        vecs[0]  = '{1, 0, 0, 9'b0_0_0_0_0_0_000};   // reset state
        vecs[1]  = '{0, 1, 1, 9'b0_0_0_0_0_0_000};   // abort beats start
        vecs[2]  = '{0, 1, 0, 9'b1_0_0_0_0_0_000};   // LOAD
        vecs[3]  = '{0, 0, 0, 9'b1_1_0_0_0_0_000};   // first SETTLE
        vecs[4]  = '{0, 1, 0, 9'b1_0_0_0_0_0_000};   // start while busy
        vecs[5]  = '{0, 0, 0, 9'b1_0_0_0_1_0_000};   // no restart; TC0->1 rise
        vecs[6]  = '{0, 0, 1, 9'b0_0_0_0_0_0_000};   // abort
        vecs[7]  = '{1, 1, 0, 9'b0_0_0_0_0_0_000};   // rst beats start
        vecs[8]  = '{0, 1, 0, 9'b1_0_0_0_0_0_000};
        vecs[9]  = '{0, 0, 0, 9'b1_1_0_0_0_0_000};
        vecs[10] = '{1, 0, 0, 9'b0_0_0_0_0_0_000};   // rst mid-sweep
        vecs[11] = '{0, 0, 0, 9'b0_0_0_0_0_0_000};

        repeat (3) @(negedge clk_100m);
        for (int i = 0; i < 12; i++) begin
            rst = vecs[i].rst; start = vecs[i].start; abort = vecs[i].abort;
            @(negedge clk_100m);
            n_vec++;
            if ({busy, pt_start, pt_done, done, samp_clk, sample_stb, pt_idx} !== vecs[i].exp) begin
                n_err++;
                $display("FAIL vec%0d: got %b, want %b", i,
                         {busy, pt_start, pt_done, done, samp_clk, sample_stb, pt_idx}, vecs[i].exp);
            end
        end
        rst = 1'b0; start = 1'b0; abort = 1'b0;
        mon_en = 1'b1;

`ifdef CONT_SWEEP_EN
        wr(3'd0, 4);
        start = 1'b1;
        l = cyc + 1;
        @(negedge clk_100m);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            push_point(l, 4, 0, w0);
            push_point(w0 + 1, 1, 1, w1);
            l = w1 + 1;
        end
        wait_until(w1);
        abort = 1'b1;
        @(negedge clk_100m);
        abort = 1'b0;
        check("cont_abort_busy_done", {busy, pt_done}, 2'b00);
        repeat (20) @(negedge clk_100m);
        check("cont_sb_empty", sb.size(), 0);
`else
        // Reset must clear the table: both points fall back to TC 0 -> 1.
        wr(3'd0, 4);
        wr(3'd1, 5);
        rst = 1'b1;
        repeat (2) @(negedge clk_100m);
        rst = 1'b0;
        run_sweep(1, 1, 0);

        // Table {4, 0}: periods 10 and 4.
        wr(3'd0, 4);
        run_sweep(4, 1, 0);

        // Held-off ack.
        pt_ack = 1'b0;
        start = 1'b1;
        l = cyc + 1;
        @(negedge clk_100m);
        start = 1'b0;
        push_point(l, 4, 0, w0);
        wait_until(w0);
        for (int i = 0; i < 20; i++) begin
            check("ack_hold", {pt_done, sample_stb, pt_idx}, 5'b10000);
            @(negedge clk_100m);
        end
        check("ack_hold_last", pt_done, 1);
        pt_ack = 1'b1;
        a = cyc;
        @(negedge clk_100m);
        check("ack_load", {busy, pt_done, pt_idx}, 5'b10001);
        push_point(a + 1, 1, 1, w1);
        push_ev(EV_DONE, w1 + 1, 1);
        wait_until(w1 + 3);
        check("ack_end_busy", busy, 0);
        check("ack_sb_empty", sb.size(), 0);

        // Abort on the second strobe of point 0.
        start = 1'b1;
        l = cyc + 1;
        @(negedge clk_100m);
        start = 1'b0;
        push_ev(EV_PTSTART, l + 1, 0);
        push_ev(EV_STB, l + 17, 0);
        push_ev(EV_STB, l + 27, 0);
        wait_until(l + 27);
        check("abort_pre_samp_clk", samp_clk, 1);
        abort = 1'b1;
        @(negedge clk_100m);
        abort = 1'b0;
        check("abort_outs", {busy, samp_clk, sample_stb, pt_done, done}, 5'b00000);
        repeat (60) @(negedge clk_100m);
        check("abort_idle", busy, 0);
        check("abort_sb_empty", sb.size(), 0);
        run_sweep(4, 1, 0);

        // Write while busy is dropped; idle writes land, out-of-range dropped.
        run_sweep(4, 1, 1);
        wr(3'd1, 7);
        wr(3'd3, 2);
        wr(3'd2, 9);
        run_sweep(4, 7, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
